// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter: arbitration FSM states and the
// memory-port owner encoding (the access states reuse the owner codes).
package mem_arb_pkg;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_DATA  = 2'd1;
  localparam logic [1:0] OWN_FETCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = OWN_NONE,
    DATA_ACC  = OWN_DATA,
    FETCH_ACC = OWN_FETCH
  } arb_state_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Access wait counter: cleared on every grant, counts each active cycle and
// flags the cycle in which the access has waited MAX_WAIT cycles.
module mem_arb_wdog #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = i_run & (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter serialising instruction fetch and data load/store onto one memory
// port. Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation by data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_WAIT     = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchValid,
  output logic [DATA_W-1:0] FetchData,
  input  logic              DataRE,
  input  logic              DataWE,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWData,
  output logic              DataValid,
  output logic [DATA_W-1:0] DataRData,
  output logic              Stall,
  output logic              MemEn,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemReady,
  output logic              MemError
);

  if (MAX_WAIT < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("mem_arbiter: MAX_WAIT must be >= 2 and STARVE_LIMIT >= 1");
  end

  arb_state_t        r_state, w_next;
  logic              w_data_req, w_active, w_timeout, w_done, w_tmo_err;
  logic              w_grant_data, w_grant_fetch, w_force_fetch;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, w_rdata;
  logic              r_we, r_error;

  assign w_data_req = DataRE | DataWE;
  assign w_active   = (r_state != IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  // Counts data grants won while fetch was waiting; never passes the limit
  // because reaching it forces the next grant to fetch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_starve <= '0;
    end else if (w_grant_fetch) begin
      r_starve <= '0;
    end else if (w_grant_data) begin
      r_starve <= FetchReq ? r_starve + 1'b1 : '0;
    end
  end

  assign w_force_fetch = FetchReq & (r_starve >= SW'(STARVE_LIMIT));
`else
  assign w_force_fetch = 1'b0;
`endif

  mem_arb_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .Clock     (Clock),
    .Reset     (Reset),
    .i_clear   (w_grant_data | w_grant_fetch),
    .i_run     (w_active),
    .o_timeout (w_timeout)
  );

  assign w_done    = w_active & (MemReady | w_timeout);
  assign w_tmo_err = w_active & w_timeout & ~MemReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_data_req && !w_force_fetch) begin
          w_grant_data = 1'b1;
          w_next       = DATA_ACC;
        end else if (FetchReq) begin
          w_grant_fetch = 1'b1;
          w_next        = FETCH_ACC;
        end
      end
      DATA_ACC, FETCH_ACC: begin
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_grant_data) begin
        r_addr  <= DataAddr;
        r_wdata <= DataWData;
        r_we    <= DataWE;
      end else if (w_grant_fetch) begin
        r_addr <= FetchAddr;
        r_we   <= 1'b0;
      end
      if (w_tmo_err) r_error <= 1'b1;
    end
  end

  // A MemReady coinciding with the timeout cycle still returns real data.
  assign w_rdata    = MemReady ? MemRData : '0;
  assign DataValid  = w_done & (r_state == DATA_ACC);
  assign FetchValid = w_done & (r_state == FETCH_ACC);
  assign DataRData  = DataValid  ? w_rdata : '0;
  assign FetchData  = FetchValid ? w_rdata : '0;

  assign MemEn    = w_active;
  assign MemWE    = w_active & r_we;
  assign MemAddr  = r_addr;
  assign MemWData = r_wdata;
  assign MemError = r_error;

  assign Stall = (w_data_req & ~DataValid) | (FetchReq & ~FetchValid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level memory and arbitration model.
module tb_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXW = 16;
  localparam int unsigned SLIM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          FetchReq = 1'b0, DataRE = 1'b0, DataWE = 1'b0;
  logic [AW-1:0] FetchAddr = '0, DataAddr = '0;
  logic [DW-1:0] DataWData = '0;
  logic          FetchValid, DataValid, Stall, MemEn, MemWE, MemError;
  logic [DW-1:0] FetchData, DataRData, MemWData;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemRData = '0;
  logic          MemReady = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .STARVE_LIMIT(SLIM)) dut (
    .Clock(clk), .Reset(rst),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchValid(FetchValid), .FetchData(FetchData),
    .DataRE(DataRE), .DataWE(DataWE), .DataAddr(DataAddr), .DataWData(DataWData),
    .DataValid(DataValid), .DataRData(DataRData), .Stall(Stall),
    .MemEn(MemEn), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady), .MemError(MemError)
  );

  // Memory behind the port, plus the bench's own view of what it should hold.
  logic [DW-1:0] dut_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int mem_delay = 0;
  bit mem_never = 1'b0, rand_delay = 1'b0, idle_noise = 1'b0;
  int resp_cnt = 0, cur_delay = 0;

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  always @(posedge clk) begin
    #1;
    if (MemEn === 1'b1) begin
      if (resp_cnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 4)) : mem_delay;
      MemReady = !mem_never && (resp_cnt == cur_delay);
      resp_cnt++;
      if (MemReady) begin
        if (MemWE) dut_mem[MemAddr] = MemWData;
        MemRData = dut_mem.exists(MemAddr) ? dut_mem[MemAddr] : mem_init(MemAddr);
      end else begin
        MemRData = $urandom;
      end
    end else begin
      resp_cnt = 0;
      MemReady = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      MemRData = $urandom;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; FetchReq = 1'b0; DataRE = 1'b0; DataWE = 1'b0;
    mem_never = 1'b0; rand_delay = 1'b0; idle_noise = 1'b0; mem_delay = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (MemEn !== 1'b0 || MemWE !== 1'b0) begin errors++;
      $display("FAIL reset_en: got en=%b we=%b expected 0 0", MemEn, MemWE); end
    checks++; if (FetchValid !== 1'b0 || DataValid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got f=%b d=%b expected 0 0", FetchValid, DataValid); end
    checks++; if (MemAddr !== '0 || MemWData !== '0) begin errors++;
      $display("FAIL reset_regs: got addr=%h wdata=%h expected 0 0", MemAddr, MemWData); end
    checks++; if (FetchData !== '0 || DataRData !== '0 || MemError !== 1'b0 || Stall !== 1'b0) begin errors++;
      $display("FAIL reset_misc: got fd=%h dd=%h err=%b stall=%b expected 0", FetchData, DataRData, MemError, Stall); end
    do_reset();
  endtask

  task automatic test_fetch_only();
    do_reset();
    dut_mem[32'h40] = 32'h2008_0005;
    @(posedge clk); #1; FetchReq = 1'b1; FetchAddr = 32'h40;
    @(negedge clk);
    checks++; if (MemEn !== 1'b0 || Stall !== 1'b1) begin errors++;
      $display("FAIL fetch_idle: got en=%b stall=%b expected 0 1", MemEn, Stall); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (MemEn !== 1'b1 || MemAddr !== 32'h40 || MemWE !== 1'b0) begin errors++;
      $display("FAIL fetch_port: got en=%b addr=%h we=%b expected 1 40 0", MemEn, MemAddr, MemWE); end
    checks++; if (FetchValid !== 1'b1 || FetchData !== 32'h2008_0005) begin errors++;
      $display("FAIL fetch_data: got v=%b data=%h expected 1 20080005", FetchValid, FetchData); end
    checks++; if (Stall !== 1'b0) begin errors++;
      $display("FAIL fetch_stall_done: got %b expected 0", Stall); end
    @(posedge clk); #1; FetchReq = 1'b0;
    @(negedge clk);
    checks++; if (FetchValid !== 1'b0 || Stall !== 1'b0 || MemEn !== 1'b0) begin errors++;
      $display("FAIL fetch_after: got v=%b stall=%b en=%b expected 0 0 0", FetchValid, Stall, MemEn); end
  endtask

  task automatic test_simultaneous();
    int n_acc = 0, en_idx = 0;
    bit prev_en = 1'b0, fdone = 1'b0, drop_d = 1'b0, drop_f = 1'b0, exp_dv, exp_fv, exp_stall;
    logic [AW-1:0] a1 = '0, a2 = '0;
    do_reset();
    mem_delay = 1;
    @(posedge clk); #1;
    FetchReq = 1'b1; FetchAddr = 32'h200; DataRE = 1'b1; DataAddr = 32'h100;
    for (int c = 0; c < 30 && !fdone; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (drop_d) DataRE = 1'b0;
        if (drop_f) begin FetchReq = 1'b0; fdone = 1'b1; end
      end
      @(negedge clk);
      if (MemEn && !prev_en) begin
        n_acc++; en_idx = 0;
        if (n_acc == 1) a1 = MemAddr; else if (n_acc == 2) a2 = MemAddr;
      end
      if (MemEn) en_idx++;
      prev_en = MemEn;
      exp_dv = MemEn && n_acc == 1 && en_idx == 2;
      exp_fv = MemEn && n_acc == 2 && en_idx == 2;
      exp_stall = (DataRE && !exp_dv) || (FetchReq && !exp_fv);
      checks++; if (Stall !== exp_stall || DataValid !== exp_dv || FetchValid !== exp_fv) begin errors++;
        $display("FAIL simul_cycle%0d: got stall=%b dv=%b fv=%b expected %b %b %b",
                 c, Stall, DataValid, FetchValid, exp_stall, exp_dv, exp_fv); end
      if (exp_dv) drop_d = 1'b1;
      if (exp_fv) drop_f = 1'b1;
    end
    checks++; if (a1 !== 32'h100 || a2 !== 32'h200 || !fdone) begin errors++;
      $display("FAIL simul_order: got first=%h second=%h done=%b expected 100 200 1", a1, a2, fdone); end
  endtask

  task automatic test_store();
    int en_idx = 0, valid_at = 0;
    do_reset();
    mem_delay = 3;
    @(posedge clk); #1;
    DataWE = 1'b1; DataAddr = 32'h8; DataWData = 32'hDEAD_BEEF;
    for (int c = 0; c < 20 && valid_at == 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (MemEn) begin
        en_idx++;
        checks++; if (MemWE !== 1'b1 || MemAddr !== 32'h8 || MemWData !== 32'hDEAD_BEEF) begin errors++;
          $display("FAIL store_operands: got we=%b addr=%h wdata=%h expected 1 8 deadbeef", MemWE, MemAddr, MemWData); end
      end
      if (DataValid) valid_at = en_idx;
    end
    @(posedge clk); #1; DataWE = 1'b0;
    @(negedge clk);
    checks++; if (valid_at != 4) begin errors++;
      $display("FAIL store_latency: got valid in MemEn cycle %0d expected 4", valid_at); end
    checks++; if (!dut_mem.exists(32'h8) || dut_mem[32'h8] !== 32'hDEAD_BEEF || MemEn !== 1'b0) begin errors++;
      $display("FAIL store_written: got en=%b written=%b expected 0 1", MemEn, dut_mem.exists(32'h8)); end
  endtask

  task automatic test_timeout();
    int en_idx = 0, valid_at = 0;
    logic [DW-1:0] rd = '1;
    do_reset();
    mem_never = 1'b1;
    @(posedge clk); #1; DataRE = 1'b1; DataAddr = 32'h20;
    for (int c = 0; c < 40 && valid_at == 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (MemEn) en_idx++;
      if (DataValid) begin valid_at = en_idx; rd = DataRData; end
    end
    @(posedge clk); #1; DataRE = 1'b0; mem_never = 1'b0;
    @(negedge clk);
    checks++; if (valid_at != int'(MAXW) || rd !== '0) begin errors++;
      $display("FAIL timeout_valid: got cycle %0d data %h expected %0d 0", valid_at, rd, MAXW); end
    @(posedge clk); #1; FetchReq = 1'b1; FetchAddr = 32'h4;
    repeat (4) begin @(posedge clk); #1; FetchReq = 1'b0; end
    @(negedge clk);
    checks++; if (MemError !== 1'b1) begin errors++;
      $display("FAIL timeout_sticky: got MemError %b expected 1", MemError); end
    do_reset();
    checks++; if (MemError !== 1'b0) begin errors++;
      $display("FAIL timeout_clear: got MemError %b expected 0", MemError); end
  endtask

  task automatic test_reset_mid();
    int en_seen = 0;
    do_reset();
    mem_never = 1'b1;
    @(posedge clk); #1; DataRE = 1'b1; DataAddr = 32'h30;
    for (int c = 0; c < 10 && en_seen < 2; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (MemEn) en_seen++;
    end
    rst = 1'b1;
    #1;
    checks++; if (en_seen != 2 || MemEn !== 1'b0 || DataValid !== 1'b0) begin errors++;
      $display("FAIL reset_mid: got seen=%0d en=%b dv=%b expected 2 0 0", en_seen, MemEn, DataValid); end
    @(posedge clk); #1; rst = 1'b0; DataRE = 1'b0; mem_never = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (MemEn !== 1'b0 || Stall !== 1'b0 || DataValid !== 1'b0) begin errors++;
      $display("FAIL reset_mid_idle: got en=%b stall=%b dv=%b expected 0 0 0", MemEn, Stall, DataValid); end
  endtask

  task automatic test_starve();
    int nd = 0, first_f = -1, exp_f;
    do_reset();
    @(posedge clk); #1;
    FetchReq = 1'b1; FetchAddr = 32'h300; DataRE = 1'b1; DataAddr = 32'h44;
    for (int c = 0; c < 60 && first_f < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (FetchValid) first_f = nd;
      if (DataValid) nd++;
    end
    exp_f = GUARD ? int'(SLIM) : -1;
    checks++; if (first_f != exp_f) begin errors++;
      $display("FAIL starve: got data completions before fetch %0d expected %0d", first_f, exp_f); end
    do_reset();
  endtask

  task automatic test_random(input int ncyc);
    bit fpend = 1'b0, dpend = 1'b0, dwe = 1'b0, prev_en = 1'b0, idle_req = 1'b0;
    bit arb_f = 1'b0, arb_d = 1'b0, exp_dv, exp_fv, exp_stall;
    logic [AW-1:0] faddr = '0, daddr = '0;
    logic [DW-1:0] dwdata = '0, exp_rd;
    int owner = 0, en_idx = 0, streak = 0, kind;
    do_reset();
    rand_delay = 1'b1; idle_noise = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (!fpend && $urandom_range(0, 2) == 0) begin
        fpend = 1'b1; faddr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1'b1; kind = int'($urandom_range(0, 2)); dwe = (kind != 0);
        daddr = 32'($urandom_range(0, 15)) << 2; dwdata = $urandom;
        DataRE = (kind != 1); DataWE = dwe;
      end
      if (!dpend) begin DataRE = 1'b0; DataWE = 1'b0; end
      DataAddr  = dpend ? daddr : $urandom;
      DataWData = dpend ? dwdata : $urandom;
      FetchReq  = fpend;
      FetchAddr = fpend ? faddr : $urandom;
      @(negedge clk);
      if (!prev_en) begin
        checks++; if (MemEn !== idle_req) begin errors++;
          $display("FAIL rnd_grant c%0d: got MemEn %b expected %b", c, MemEn, idle_req); end
      end
      if (MemEn && !prev_en) begin
        en_idx = 0;
        if (arb_f && (!arb_d || (GUARD && streak >= int'(SLIM)))) begin owner = 2; streak = 0; end
        else begin owner = 1; streak = arb_f ? streak + 1 : 0; end
      end
      if (MemEn) begin
        en_idx++;
        checks++;
        if (MemAddr !== (owner == 1 ? daddr : faddr) || MemWE !== (owner == 1 && dwe)
            || (owner == 1 && dwe && MemWData !== dwdata)) begin errors++;
          $display("FAIL rnd_port c%0d: got addr=%h we=%b wd=%h expected owner %0d addr=%h",
                   c, MemAddr, MemWE, MemWData, owner, owner == 1 ? daddr : faddr); end
      end
      exp_dv = MemEn && owner == 1 && (MemReady || en_idx == int'(MAXW));
      exp_fv = MemEn && owner == 2 && (MemReady || en_idx == int'(MAXW));
      checks++; if (DataValid !== exp_dv || FetchValid !== exp_fv) begin errors++;
        $display("FAIL rnd_valid c%0d: got dv=%b fv=%b expected %b %b", c, DataValid, FetchValid, exp_dv, exp_fv); end
      if (exp_fv) begin
        exp_rd = MemReady ? ref_read(faddr) : '0;
        checks++; if (FetchData !== exp_rd) begin errors++;
          $display("FAIL rnd_fdata c%0d: got %h expected %h", c, FetchData, exp_rd); end
      end
      if (exp_dv && !dwe) begin
        exp_rd = MemReady ? ref_read(daddr) : '0;
        checks++; if (DataRData !== exp_rd) begin errors++;
          $display("FAIL rnd_ddata c%0d: got %h expected %h", c, DataRData, exp_rd); end
      end
      exp_stall = (dpend && !exp_dv) || (fpend && !exp_fv);
      checks++; if (Stall !== exp_stall || MemError !== 1'b0) begin errors++;
        $display("FAIL rnd_stall c%0d: got stall=%b err=%b expected %b 0", c, Stall, MemError, exp_stall); end
      if (exp_dv) begin dpend = 1'b0; if (dwe) ref_mem[daddr] = dwdata; end
      if (exp_fv) fpend = 1'b0;
      arb_f = fpend; arb_d = dpend;
      idle_req = !MemEn && (fpend || dpend);
      prev_en = MemEn;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_store();
    test_timeout();
    test_reset_mid();
    test_starve();
    dut_mem.delete();
    ref_mem.delete();
    test_random(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
